grid_diff_scanner: RTL and testbench

- Parametrised frame-diff engine for the snake image generator.
- Raster-scans a GRID_W x GRID_H cell map, one cell per cycle, and priority-encodes the game-logic object flags for the current cell.
- Compares the result against a private shadow frame buffer and stalls on each changed cell until the display driver acknowledges the draw via cmd_done.
- Over the previous generation it adds: generic grid size, forced full redraw, a game-over fill mode, a per-frame change counter, and explicit start/busy/frame_done handshaking.

---
 rtl/grid_diff_scanner.sv | 100 ++++++++++
 tb/tb_grid_diff_scanner.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/grid_diff_scanner.sv
// grid_diff_scanner: raster-scans the cell map, encodes object flags and
// requests a redraw for every cell that differs from the shadow frame.
module grid_diff_scanner #(
    parameter int GRID_W = 16,
    parameter int GRID_H = 12,
    parameter int XW = 4,
    parameter int YW = 4,
    parameter int CW = 3,
    localparam int NW = $clog2(GRID_W * GRID_H + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          force_redraw,
    input  logic          game_over,
    input  logic          snake_head,
    input  logic          snake_body,
    input  logic          apple,
    input  logic          border,
    input  logic          cmd_done,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] obj_code,
    output logic          diff,
    output logic          init_cycle,
    output logic          busy,
    output logic          frame_done,
    output logic [NW-1:0] diff_count
);
    typedef enum logic [1:0] {IDLE, SCAN, WAIT_CMD, DONE} state_t;
    state_t state, state_n;
    logic [CW-1:0] shadow [GRID_H][GRID_W];
    logic [CW-1:0] code;
    logic [NW-1:0] cnt;
    logic full, redraw_pending, changed, x_end, last, adv, draw;

    assign code = game_over ? CW'(5) : snake_head ? CW'(4) : snake_body ? CW'(3) :
                  apple ? CW'(2) : border ? CW'(1) : CW'(0);
    assign changed = full || code != shadow[y][x];
    assign x_end = x == XW'(GRID_W - 1);
    assign last = x_end && y == YW'(GRID_H - 1);
    assign draw = state == WAIT_CMD && cmd_done;
    assign adv = (state == SCAN && !changed) || draw;
    assign busy = state != IDLE;
    assign diff = state == WAIT_CMD;
    assign frame_done = state == DONE;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = start ? SCAN : IDLE;
            SCAN:     state_n = changed ? WAIT_CMD : last ? DONE : SCAN;
            WAIT_CMD: state_n = !cmd_done ? WAIT_CMD : last ? DONE : SCAN;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
            obj_code <= '0;
            diff_count <= '0;
            init_cycle <= 1'b1;
            redraw_pending <= 1'b0;
            full <= 1'b0;
            cnt <= '0;
        end else begin
            if (state == IDLE) begin
                x <= '0;
                y <= '0;
                cnt <= '0;
                full <= init_cycle || redraw_pending || force_redraw;
                // a redraw request made while idle survives until a frame starts
                redraw_pending <= !start && (redraw_pending || force_redraw);
            end else begin
                redraw_pending <= redraw_pending || force_redraw;
            end
            if (state == SCAN && changed)
                obj_code <= code;
            if (draw)
                cnt <= cnt + 1'b1;
            if (adv) begin
                x <= x_end ? '0 : x + 1'b1;
                y <= last ? '0 : x_end ? y + 1'b1 : y;
                if (last) begin
                    diff_count <= cnt + NW'(draw);
                    init_cycle <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk)
        if (draw)
            shadow[y][x] <= obj_code;
endmodule

// File: tb/tb_grid_diff_scanner.sv
// tb_grid_diff_scanner: directed frames with a scoreboard of expected draw
// requests and per-frame change counts, checked by independent monitors.
module tb_grid_diff_scanner;
    logic clk = 1'b0, rst = 1'b1;
    logic go = 1'b0, stray_start = 1'b0, force_redraw = 1'b0, game_over = 1'b0;
    logic resp_cd = 1'b0, stray_cd = 1'b0, hold93 = 1'b0;
    logic start, cmd_done, snake_head, snake_body, apple, border;
    logic [3:0] x, y;
    logic [2:0] obj_code;
    logic diff, init_cycle, busy, frame_done;
    logic [7:0] diff_count;
    logic [3:0] hx = 4, hy = 4, bx = 0, by = 0, ax = 7, ay = 4;
    logic body_on = 1'b0;
    logic [2:0] obs [12][16];

    typedef struct {int x; int y; int c;} ent_t;
    ent_t dq[$];
    int cq[$];
    int nvec = 0, nerr = 0;

    assign start = go | stray_start;
    assign cmd_done = resp_cd | stray_cd;

    always #5 clk = ~clk;

    grid_diff_scanner dut (
        .clk(clk), .rst(rst), .start(start), .force_redraw(force_redraw),
        .game_over(game_over), .snake_head(snake_head), .snake_body(snake_body),
        .apple(apple), .border(border), .cmd_done(cmd_done), .x(x), .y(y),
        .obj_code(obj_code), .diff(diff), .init_cycle(init_cycle), .busy(busy),
        .frame_done(frame_done), .diff_count(diff_count)
    );

    always_comb begin
        border = x == 0 || x == 15 || y == 0 || y == 11;
        snake_head = x == hx && y == hy;
        snake_body = body_on && x == bx && y == by;
        apple = x == ax && y == ay;
    end

    task automatic check(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int cell_code(input int cx, input int cy);
        if (game_over) return 5;
        if (cx == hx && cy == hy) return 4;
        if (body_on && cx == bx && cy == by) return 3;
        if (cx == ax && cy == ay) return 2;
        if (cx == 0 || cx == 15 || cy == 0 || cy == 11) return 1;
        return 0;
    endfunction

    task automatic push_full();
        for (int j = 0; j < 12; j++)
            for (int i = 0; i < 16; i++)
                dq.push_back('{i, j, cell_code(i, j)});
    endtask

    task automatic run_frame(output int nb);
        int t;
        nb = 0;
        t = 0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        while (busy && t < 20000) begin
            nb++;
            t++;
            @(negedge clk);
        end
        if (t >= 20000) check("frame_timeout", t, 0);
    endtask

    // display-driver model: acknowledge each request five cycles after it appears
    initial begin
        forever begin
            @(negedge clk);
            if (diff && !rst && !(hold93 && x == 9 && y == 3)) begin
                repeat (4) @(negedge clk);
                resp_cd = 1'b1;
                @(negedge clk);
                resp_cd = 1'b0;
            end
        end
    end

    initial begin
        logic prev;
        ent_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) prev = 1'b0;
            else begin
                if (diff && !prev) begin
                    obs[y][x] = obj_code;
                    if (dq.size() == 0) check("unexpected_diff", 1, 0);
                    else begin
                        e = dq.pop_front();
                        check($sformatf("diff_x(%0d,%0d)", e.x, e.y), int'(x), e.x);
                        check($sformatf("diff_y(%0d,%0d)", e.x, e.y), int'(y), e.y);
                        check($sformatf("code(%0d,%0d)", e.x, e.y), int'(obj_code), e.c);
                    end
                end
                prev = diff;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (frame_done && !rst) begin
                if (cq.size() == 0) check("unexpected_frame_done", 1, 0);
                else check("diff_count", int'(diff_count), cq.pop_front());
                check("init_cycle_done", int'(init_cycle), 0);
                check("missing_diffs", dq.size(), 0);
            end
        end
    end

    initial begin
        int nb, t, bsum;
        repeat (2) @(negedge clk);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_diff", int'(diff), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_init", int'(init_cycle), 1);
        check("rst_count", int'(diff_count), 0);
        rst = 1'b0;
        @(negedge clk);

        push_full();
        cq.push_back(192);
        run_frame(nb);
        check("obs_0_0", int'(obs[0][0]), 1);
        check("obs_4_4", int'(obs[4][4]), 4);
        check("obs_7_4", int'(obs[4][7]), 2);
        check("obs_1_1", int'(obs[1][1]), 0);

        cq.push_back(0);
        fork
            run_frame(nb);
            begin
                repeat (30) @(negedge clk);
                stray_cd = 1'b1;
                stray_start = 1'b1;
                @(negedge clk);
                stray_cd = 1'b0;
                stray_start = 1'b0;
            end
        join
        check("idle_frame_cycles", nb, 193);
        bsum = 0;
        repeat (5) begin
            @(negedge clk);
            bsum += int'(busy);
        end
        check("start_not_queued", bsum, 0);

        hx = 5;
        body_on = 1'b1;
        bx = 4;
        by = 4;
        dq.push_back('{4, 4, 3});
        dq.push_back('{5, 4, 4});
        cq.push_back(2);
        run_frame(nb);
        check("two_diff_cycles", nb, 203);

        cq.push_back(0);
        fork
            run_frame(nb);
            begin
                repeat (50) @(negedge clk);
                force_redraw = 1'b1;
                @(negedge clk);
                force_redraw = 1'b0;
            end
        join
        check("redraw_frame_unaffected", nb, 193);
        push_full();
        cq.push_back(192);
        run_frame(nb);

        game_over = 1'b1;
        push_full();
        cq.push_back(192);
        run_frame(nb);
        check("obs_go_1_1", int'(obs[1][1]), 5);
        game_over = 1'b0;

        hold93 = 1'b1;
        push_full();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        t = 0;
        while (!(diff && x == 9 && y == 3) && t < 5000) begin
            t++;
            @(negedge clk);
        end
        if (t >= 5000) check("wait_9_3_timeout", t, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_diff", int'(diff), 0);
        check("mid_rst_x", int'(x), 0);
        check("mid_rst_y", int'(y), 0);
        check("mid_rst_init", int'(init_cycle), 1);
        rst = 1'b0;
        hold93 = 1'b0;
        dq.delete();
        cq.delete();
        @(negedge clk);
        push_full();
        cq.push_back(192);
        run_frame(nb);
        check("post_rst_init", int'(init_cycle), 0);
        repeat (3) @(negedge clk);
        check("leftover_diffs", dq.size(), 0);
        check("leftover_frames", cq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
